// File: rtl/skin_mask_stats.sv
// skin_mask_stats
//   Thresholds an HSV pixel stream into a binary skin mask, forwards the mask
//   with the stream controls delayed by one ce-qualified cycle, and gathers
//   per-frame skin statistics (count, bounding box, centroid). The centroid
//   is produced by a restoring divider that runs during vertical blanking.
//
// Optional feature: define SKIN_BBOX_EN to build the bounding-box trackers.
//   Without it, x_min/x_max/y_min/y_max are constant 0.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   ce                         pixel clock enable for the stream side
//   de_in/hsync_in/vsync_in    stream controls (active high)
//   H, S, V                    pixel components
//   h_/s_/v_ min/max           inclusive thresholds (hue band may wrap)
//   mask_out, de/hsync/vsync_out   registered stream outputs
//   pix_count, x_min..y_max, cx, cy   statistics of the last published frame
//   stats_valid                one-cycle pulse when statistics update
//   overrun                    sticky: frame end arrived while busy
module skin_mask_stats #(
    parameter int unsigned XW = 11,
    parameter int unsigned YW = 11,
    parameter int unsigned CW = 22
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ce,
    input  logic          de_in,
    input  logic          hsync_in,
    input  logic          vsync_in,
    input  logic [7:0]    H,
    input  logic [7:0]    S,
    input  logic [7:0]    V,
    input  logic [7:0]    h_min,
    input  logic [7:0]    h_max,
    input  logic [7:0]    s_min,
    input  logic [7:0]    s_max,
    input  logic [7:0]    v_min,
    input  logic [7:0]    v_max,
    output logic          mask_out,
    output logic          de_out,
    output logic          hsync_out,
    output logic          vsync_out,
    output logic [CW-1:0] pix_count,
    output logic [XW-1:0] x_min,
    output logic [XW-1:0] x_max,
    output logic [YW-1:0] y_min,
    output logic [YW-1:0] y_max,
    output logic [XW-1:0] cx,
    output logic [YW-1:0] cy,
    output logic          stats_valid,
    output logic          overrun
);

    localparam int unsigned SX = XW + CW;
    localparam int unsigned SY = YW + CW;
    localparam int unsigned DW = (SX > SY) ? SX : SY;
    localparam int unsigned NW = $clog2(DW) + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DIV_X,
        ST_DIV_Y,
        ST_PUBLISH,
        ST_ZERO
    } state_e;

    // ------------------------------------------------------------------
    // Stream stage
    // ------------------------------------------------------------------
    logic          mask_q, de_q, hs_q, vs_q;
    logic [XW-1:0] x_q, x_d, cur_x;
    logic [YW-1:0] y_q, y_d, cur_y;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SX-1:0] sx_q, sx_d;
    logic [SY-1:0] sy_q, sy_d;

    logic hue_ok, mask_c, vs_rise, de_fall, pix_hit;

    // Hue band: a normal range, or a wrap-around band when h_min > h_max
    always_comb begin
        hue_ok = 1'b0;
        if (h_min <= h_max) begin
            hue_ok = (H >= h_min) && (H <= h_max);
        end else begin
            hue_ok = (H >= h_min) || (H <= h_max);
        end
    end

    assign mask_c  = de_in & hue_ok & (S >= s_min) & (S <= s_max)
                                    & (V >= v_min) & (V <= v_max);
    // de_q/vs_q are the previous ce-sampled controls, so they double as edge detectors
    assign vs_rise = ce & vsync_in & ~vs_q;
    assign de_fall = ce & de_q & ~de_in;
    assign pix_hit = ce & mask_c;

    // Position counters and live accumulators; an edge-cycle pixel starts the new frame
    always_comb begin
        cur_x = vs_rise ? '0 : x_q;
        cur_y = vs_rise ? '0 : y_q;
        x_d   = x_q;
        y_d   = y_q;
        cnt_d = vs_rise ? '0 : cnt_q;
        sx_d  = vs_rise ? '0 : sx_q;
        sy_d  = vs_rise ? '0 : sy_q;
        if (pix_hit) begin
            cnt_d = cnt_d + CW'(1);
            sx_d  = sx_d + SX'(cur_x);
            sy_d  = sy_d + SY'(cur_y);
        end
        if (ce) begin
            if (de_in) begin
                x_d = cur_x + XW'(1);
            end else if (de_fall) begin
                x_d = '0;
            end else begin
                x_d = cur_x;
            end
            y_d = de_fall ? cur_y + YW'(1) : cur_y;
        end
    end

    // Stream registers advance only on ce
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mask_q <= 1'b0;
            de_q   <= 1'b0;
            hs_q   <= 1'b0;
            vs_q   <= 1'b0;
            x_q    <= '0;
            y_q    <= '0;
            cnt_q  <= '0;
            sx_q   <= '0;
            sy_q   <= '0;
        end else if (ce) begin
            mask_q <= mask_c;
            de_q   <= de_in;
            hs_q   <= hsync_in;
            vs_q   <= vsync_in;
            x_q    <= x_d;
            y_q    <= y_d;
            cnt_q  <= cnt_d;
            sx_q   <= sx_d;
            sy_q   <= sy_d;
        end
    end

`ifdef SKIN_BBOX_EN
    logic [XW-1:0] bx_min_q, bx_min_d, bx_max_q, bx_max_d;
    logic [YW-1:0] by_min_q, by_min_d, by_max_q, by_max_d;

    // Bounding-box compare-and-replace; empty box is mins all-ones, maxes zero
    always_comb begin
        bx_min_d = vs_rise ? '1 : bx_min_q;
        bx_max_d = vs_rise ? '0 : bx_max_q;
        by_min_d = vs_rise ? '1 : by_min_q;
        by_max_d = vs_rise ? '0 : by_max_q;
        if (pix_hit) begin
            if (cur_x < bx_min_d) bx_min_d = cur_x;
            if (cur_x > bx_max_d) bx_max_d = cur_x;
            if (cur_y < by_min_d) by_min_d = cur_y;
            if (cur_y > by_max_d) by_max_d = cur_y;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bx_min_q <= '1;
            bx_max_q <= '0;
            by_min_q <= '1;
            by_max_q <= '0;
        end else if (ce) begin
            bx_min_q <= bx_min_d;
            bx_max_q <= bx_max_d;
            by_min_q <= by_min_d;
            by_max_q <= by_max_d;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Snapshot and centroid divider
    // ------------------------------------------------------------------
    state_e        state_q;
    logic          pend_q, ovr_q, valid_q;
    logic [CW-1:0] snap_cnt_q;
    logic [SX-1:0] snap_sx_q;
    logic [SY-1:0] snap_sy_q;
    logic [CW-1:0] rem_q, rem_nxt;
    logic [DW-1:0] dvd_q, quo_q, quo_nxt;
    logic [NW-1:0] bit_q;
    logic [XW-1:0] cx_res_q, cx_q;
    logic [YW-1:0] cy_q;
    logic [CW-1:0] pix_count_q;
    logic [CW:0]   trial_c;
    logic          ge_c;
    logic          busy_c;

`ifdef SKIN_BBOX_EN
    logic [XW-1:0] snap_xmin_q, snap_xmax_q, x_min_q, x_max_q;
    logic [YW-1:0] snap_ymin_q, snap_ymax_q, y_min_q, y_max_q;
`endif

    // One restoring shift-subtract step: the divisor is the snapshot count
    always_comb begin
        trial_c = {rem_q, dvd_q[DW-1]};
        ge_c    = trial_c >= {1'b0, snap_cnt_q};
        rem_nxt = ge_c ? CW'(trial_c - {1'b0, snap_cnt_q}) : CW'(trial_c);
        quo_nxt = {quo_q[DW-2:0], ge_c};
    end

    // A pending snapshot counts as busy so a second edge cannot overwrite it
    assign busy_c = (state_q != ST_IDLE) || pend_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pend_q      <= 1'b0;
            ovr_q       <= 1'b0;
            valid_q     <= 1'b0;
            snap_cnt_q  <= '0;
            snap_sx_q   <= '0;
            snap_sy_q   <= '0;
            rem_q       <= '0;
            dvd_q       <= '0;
            quo_q       <= '0;
            bit_q       <= '0;
            cx_res_q    <= '0;
            cx_q        <= '0;
            cy_q        <= '0;
            pix_count_q <= '0;
`ifdef SKIN_BBOX_EN
            snap_xmin_q <= '1;
            snap_xmax_q <= '0;
            snap_ymin_q <= '1;
            snap_ymax_q <= '0;
            x_min_q     <= '0;
            x_max_q     <= '0;
            y_min_q     <= '0;
            y_max_q     <= '0;
`endif
        end else begin
            valid_q <= 1'b0;

            // Frame end: capture the live accumulators, or flag overrun if busy
            if (vs_rise) begin
                if (busy_c) begin
                    ovr_q <= 1'b1;
                end else begin
                    pend_q     <= 1'b1;
                    snap_cnt_q <= cnt_q;
                    snap_sx_q  <= sx_q;
                    snap_sy_q  <= sy_q;
`ifdef SKIN_BBOX_EN
                    snap_xmin_q <= bx_min_q;
                    snap_xmax_q <= bx_max_q;
                    snap_ymin_q <= by_min_q;
                    snap_ymax_q <= by_max_q;
`endif
                end
            end

            case (state_q)
                ST_IDLE: begin
                    if (pend_q) begin
                        pend_q <= 1'b0;
                        if (snap_cnt_q == '0) begin
                            state_q <= ST_ZERO;
                        end else begin
                            // Dividend left-aligned so its MSB is shifted in first
                            dvd_q   <= DW'(snap_sx_q) << (DW - SX);
                            rem_q   <= '0;
                            quo_q   <= '0;
                            bit_q   <= '0;
                            state_q <= ST_DIV_X;
                        end
                    end
                end
                ST_DIV_X: begin
                    rem_q <= rem_nxt;
                    dvd_q <= dvd_q << 1;
                    quo_q <= quo_nxt;
                    bit_q <= bit_q + NW'(1);
                    if (bit_q == NW'(SX - 1)) begin
                        cx_res_q <= XW'(quo_nxt);
                        dvd_q    <= DW'(snap_sy_q) << (DW - SY);
                        rem_q    <= '0;
                        quo_q    <= '0;
                        bit_q    <= '0;
                        state_q  <= ST_DIV_Y;
                    end
                end
                ST_DIV_Y: begin
                    rem_q <= rem_nxt;
                    dvd_q <= dvd_q << 1;
                    quo_q <= quo_nxt;
                    bit_q <= bit_q + NW'(1);
                    if (bit_q == NW'(SY - 1)) begin
                        state_q <= ST_PUBLISH;
                    end
                end
                ST_PUBLISH: begin
                    pix_count_q <= snap_cnt_q;
                    cx_q        <= cx_res_q;
                    cy_q        <= YW'(quo_q);
`ifdef SKIN_BBOX_EN
                    x_min_q     <= snap_xmin_q;
                    x_max_q     <= snap_xmax_q;
                    y_min_q     <= snap_ymin_q;
                    y_max_q     <= snap_ymax_q;
`endif
                    valid_q     <= 1'b1;
                    state_q     <= ST_IDLE;
                end
                ST_ZERO: begin
                    pix_count_q <= '0;
                    cx_q        <= '0;
                    cy_q        <= '0;
`ifdef SKIN_BBOX_EN
                    x_min_q     <= '0;
                    x_max_q     <= '0;
                    y_min_q     <= '0;
                    y_max_q     <= '0;
`endif
                    valid_q     <= 1'b1;
                    state_q     <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign mask_out    = mask_q;
    assign de_out      = de_q;
    assign hsync_out   = hs_q;
    assign vsync_out   = vs_q;
    assign pix_count   = pix_count_q;
    assign cx          = cx_q;
    assign cy          = cy_q;
    assign stats_valid = valid_q;
    assign overrun     = ovr_q;

`ifdef SKIN_BBOX_EN
    assign x_min = x_min_q;
    assign x_max = x_max_q;
    assign y_min = y_min_q;
    assign y_max = y_max_q;
`else
    assign x_min = '0;
    assign x_max = '0;
    assign y_min = '0;
    assign y_max = '0;
`endif

endmodule

// File: doc/skin_mask_stats.md
# skin_mask_stats

Post-colour-conversion stage that consumes the HSV pixel stream (H, S, V plus de/hsync/vsync) produced by the RGB-to-HSV converter. It thresholds each pixel into a binary skin mask, forwards the mask with delayed sync signals, and accumulates per-frame skin statistics. The statistics are pixel count, bounding box and centroid. The centroid is computed by an iterative divider during vertical blanking and published once per frame for the downstream tracking logic.

## Interface
Parameters:
- XW, 11, column counter / x coordinate width
- YW, 11, row counter / y coordinate width
- CW, 22, pixel count width (XW+YW)

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- ce  in  1  pixel clock enable; the stream pipeline and counters advance only when ce=1
- de_in, hsync_in, vsync_in  in  1 each  stream controls, active high
- H, S, V  in  8 each  pixel in 0..255
- h_min, h_max, s_min, s_max, v_min, v_max  in  8 each  inclusive thresholds, quasi-static
- mask_out  out  1  skin flag for the current pixel
- de_out, hsync_out, vsync_out  out  1 each  inputs delayed to align with mask_out
- pix_count  out  CW  skin pixels in the last completed frame
- x_min, x_max  out  XW  bounding-box columns
- y_min, y_max  out  YW  bounding-box rows
- cx  out  XW  centroid column
- cy  out  YW  centroid row
- stats_valid  out  1  one-cycle pulse when all statistics outputs update
- overrun  out  1  sticky; set when a frame end arrives while the divider is busy; cleared only by reset

## Operation
- Mask test, evaluated on each ce cycle:
  - hue_ok = (h_min<=h_max) ? (h_min<=H<=h_max) : (H>=h_min || H<=h_max). The second form is the wrap-around band for red hues.
  - mask = de_in & hue_ok & s_min<=S<=s_max & v_min<=V<=v_max.
- Position counters:
  - x increments on each ce cycle with de_in=1.
  - x clears to 0 on the de falling edge.
  - y increments on the de falling edge.
  - x and y both clear on the vsync rising edge.
  - The first active pixel of a frame is (0,0).
- Accumulators, updated for each masked pixel:
  - count += 1
  - sum_x += x, width XW+CW
  - sum_y += y, width YW+CW
  - x_min/x_max and y_min/y_max are tracked with compare-and-replace.
- Frame end is the vsync rising edge, sampled with ce=1:
  - All accumulators are copied into snapshot registers.
  - The live accumulators reset to their empty state: count/sums 0, mins all-ones, maxes 0.
  - A pixel arriving in the same cycle as the edge belongs to the new frame.
- Divider FSM (runs on every clk, independent of ce):
  - IDLE: on a snapshot, go to ZERO if count==0, else to DIV_X.
  - DIV_X: restoring shift-subtract, one quotient bit per cycle, SX=XW+CW cycles; cx = floor(sum_x/count).
  - DIV_Y: the same for SY=YW+CW cycles; cy = floor(sum_y/count).
  - PUBLISH: load all outputs, pulse stats_valid, return to IDLE.
  - ZERO: publish pix_count=0, bbox=0, cx=cy=0, pulse stats_valid, return to IDLE.
- Overrun: a frame end while the FSM is not IDLE sets overrun and discards the new snapshot. The division in progress completes unaffected.
- Reset:
  - Outputs: all 0.
  - x_min/y_min accumulators: all-ones.
  - FSM: IDLE.
  - A reset asserted mid-division aborts it with no stats_valid.

## Timing
- Stream latency is 1 ce-qualified cycle: mask_out/de_out/hsync_out/vsync_out are registered and update only when ce=1.
- Count=0 case: stats_valid is asserted exactly 2 clk cycles after the cycle sampling the vsync edge (snapshot cycle, then ZERO).
- Otherwise: stats_valid is asserted exactly SX+SY+2 clk cycles after the edge cycle, i.e. 68 with the default parameters.
- Statistics outputs hold their values between stats_valid pulses.
- The vertical blanking interval must be at least SX+SY+2 clk cycles long to avoid overrun.

## Configuration
- SKIN_BBOX_EN defined: bounding-box trackers and the x_min/x_max/y_min/y_max outputs are implemented as above.
- SKIN_BBOX_EN undefined:
  - The bbox logic is omitted and those outputs are constant 0.
  - Mask, count, centroid and stats_valid timing are unchanged.

## Test plan
- Reset, then drive ce=1 with no frames -> every output 0, overrun=0, no stats_valid.
- 8x4 frame, all pixels H=10 S=100 V=200, thresholds h 0..20, s 50..255, v 50..255, then vsync edge:
  - mask_out=1 for all 32 active cycles.
  - Then pix_count=32, bbox (0,7,0,3), cx=3, cy=1, with stats_valid 68 cycles after the edge.
- Hue wrap with h_min=240, h_max=15: pixels H=250, H=5 and H=100 -> mask_out 1, 1, 0 respectively.
- Frame with no matching pixels -> stats_valid 2 cycles after the edge, all statistics 0.
- Second vsync edge 20 cycles after the first, during DIV_X:
  - overrun=1.
  - The first frame's results are still published at cycle 68.
  - No second stats_valid.
- Assert rst_n=0 during DIV_Y -> no stats_valid and outputs 0; the next full frame publishes correctly.
